// File: rtl/flag_pkg.sv
// Shared types, opcode constants and helpers for the condition-flag unit.
package flag_pkg;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
    logic n;
  } flag_t;

  typedef enum logic [2:0] {
    C_NE  = 3'd0,
    C_EQ  = 3'd1,
    C_GT  = 3'd2,
    C_LT  = 3'd3,
    C_GE  = 3'd4,
    C_LE  = 3'd5,
    C_OV  = 3'd6,
    C_UNC = 3'd7
  } cond_e;

  localparam logic [31:0] OP_ADD = 32'h0;
  localparam logic [31:0] OP_SUB = 32'h1;
  localparam logic [31:0] OP_AND = 32'h2;
  localparam logic [31:0] OP_OR  = 32'h3;
  localparam logic [31:0] OP_XOR = 32'h4;
  localparam logic [31:0] OP_SHL = 32'h5;
  localparam logic [31:0] OP_SHR = 32'h6;
  localparam logic [31:0] OP_SAR = 32'h7;

  // Which flags an opcode is allowed to modify.
  function automatic flag_t upd_mask(input logic [31:0] opc);
    flag_t m;
    m = '0;
    case (opc)
      OP_ADD, OP_SUB:         m = '{z: 1'b1, c: 1'b1, v: 1'b1, n: 1'b1};
      OP_AND, OP_OR, OP_XOR:  m = '{z: 1'b1, c: 1'b0, v: 1'b0, n: 1'b0};
      OP_SHL, OP_SHR, OP_SAR: m = '{z: 1'b1, c: 1'b1, v: 1'b0, n: 1'b1};
      default:                m = '0;
    endcase
    return m;
  endfunction

  // Branch condition evaluated against a flag set.
  function automatic logic eval_cond(input flag_t f, input cond_e c);
    logic x;
    logic r;
    x = f.n ^ f.v;
    r = 1'b0;
    case (c)
      C_NE:    r = !f.z;
      C_EQ:    r = f.z;
      C_GT:    r = !f.z && !x;
      C_LT:    r = x;
      C_GE:    r = !x;
      C_LE:    r = f.z || x;
      C_OV:    r = f.v;
      C_UNC:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO save stack of flag sets with occupancy count and illegal-op pulse.
module flag_stack
  import flag_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  flag_t            din,
  output flag_t            dout,
  output logic             pop_ok,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flag_t            mem [DEPTH];
  logic             push_ok;
  logic             bad;
  logic [CNT_W-1:0] top_ptr;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_ptr = cnt - CNT_W'(1);
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign bad     = (push && pop) || (push && full) || (pop && empty);
  assign dout    = empty ? flag_t'('0) : mem[top_ptr[IDX_W-1:0]];

  // Occupancy count and registered error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= bad;
      if (push_ok)
        cnt <= cnt + CNT_W'(1);
      else if (pop_ok)
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage; contents are irrelevant once the count is cleared.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[cnt[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with ALU capture, explicit write, save stack
// and branch condition evaluation.
module flag_unit
  import flag_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alu_valid,
  input  logic [OPC_W-1:0]                   opcode,
  input  logic [DATA_W-1:0]                  aluout,
  input  logic                               alu_carry,
  input  logic                               aluovfl,
  input  logic                               flag_wr,
  input  logic [3:0]                         flag_wdata,
  input  logic                               push,
  input  logic                               pop,
  input  logic [2:0]                         cond,
  output flag_t                              flag,
  output logic                               cond_true,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  flag_t flag_next;
  flag_t alu_flag;
  flag_t mask;
  flag_t stack_top;
  logic  pop_ok;

  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .CNT_W (CNT_W)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (flag),
    .dout   (stack_top),
    .pop_ok (pop_ok),
    .cnt    (stack_cnt),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (stack_err)
  );

  // Priority mux: legal pop, explicit write, masked ALU update, hold.
  always_comb begin
    mask       = upd_mask(32'(opcode));
    alu_flag.z = (aluout == '0);
    alu_flag.c = alu_carry;
    alu_flag.v = aluovfl;
    alu_flag.n = aluout[DATA_W-1];
    flag_next  = flag;
    if (pop_ok)
      flag_next = stack_top;
    else if (flag_wr)
      flag_next = flag_t'(flag_wdata);
    else if (alu_valid)
      flag_next = (alu_flag & mask) | (flag & ~mask);
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flag <= '0;
    else
      flag <= flag_next;
  end

  assign cond_true = eval_cond(flag, cond_e'(cond));

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit.
module tb_flag_unit;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  opcode;
  logic [15:0] aluout;
  logic        alu_carry;
  logic        aluovfl;
  logic        flag_wr;
  logic [3:0]  flag_wdata;
  logic        push;
  logic        pop;
  logic [2:0]  cond;
  logic [3:0]  flag;
  logic        cond_true;
  logic [2:0]  stack_cnt;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;

  int checks = 0;
  int errors = 0;

  flag_unit #(
    .DATA_W      (16),
    .OPC_W       (5),
    .STACK_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .opcode      (opcode),
    .aluout      (aluout),
    .alu_carry   (alu_carry),
    .aluovfl     (aluovfl),
    .flag_wr     (flag_wr),
    .flag_wdata  (flag_wdata),
    .push        (push),
    .pop         (pop),
    .cond        (cond),
    .flag        (flag),
    .cond_true   (cond_true),
    .stack_cnt   (stack_cnt),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    flag_wr   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
  endtask

  task automatic alu(input logic [4:0] op, input logic [15:0] res, input logic c, input logic v);
    alu_valid = 1'b1;
    opcode    = op;
    aluout    = res;
    alu_carry = c;
    aluovfl   = v;
  endtask

  task automatic wr(input logic [3:0] d);
    flag_wr    = 1'b1;
    flag_wdata = d;
  endtask

  initial begin
    logic [3:0] fill [4];
    fill[0] = 4'b0001;
    fill[1] = 4'b0010;
    fill[2] = 4'b0100;
    fill[3] = 4'b1000;

    rst = 1'b0;
    idle();
    opcode = '0; aluout = '0; alu_carry = 1'b0; aluovfl = 1'b0;
    flag_wdata = '0; cond = 3'd7;
    #12;
    check("rst_flag", 16'(flag), 16'h0);
    check("rst_cnt", 16'(stack_cnt), 16'd0);
    check("rst_empty", 16'(stack_empty), 16'd1);
    check("rst_full", 16'(stack_full), 16'd0);
    check("rst_err", 16'(stack_err), 16'd0);
    rst = 1'b1;
    tick();

    // ADD: all four flags captured
    alu(5'h00, 16'h8000, 1'b1, 1'b1); cond = 3'd3;
    tick(); idle();
    check("add_flag", 16'(flag), 16'b0111);
    check("add_lt", 16'(cond_true), 16'd0);
    cond = 3'd2; #1;
    check("add_gt", 16'(cond_true), 16'd1);

    // SUB zero result
    alu(5'h01, 16'h0000, 1'b0, 1'b0);
    tick(); idle();
    check("sub_flag", 16'(flag), 16'b1000);
    cond = 3'd1; #1;
    check("sub_eq", 16'(cond_true), 16'd1);

    // AND touches Z only
    alu(5'h02, 16'h00F0, 1'b1, 1'b1);
    tick(); idle();
    check("and_flag", 16'(flag), 16'b0000);
    wr(4'b0111);
    tick(); idle();
    alu(5'h02, 16'h0000, 1'b0, 1'b0);
    tick(); idle();
    check("and_zonly", 16'(flag), 16'b1111);

    // Unmapped opcode changes nothing
    alu(5'h1F, 16'h1234, 1'b0, 1'b0);
    tick(); idle();
    check("op1f_hold", 16'(flag), 16'b1111);

    // Shift: Z, C, N updated, V held
    alu(5'h05, 16'h8000, 1'b1, 1'b0);
    tick(); idle();
    check("shl_flag", 16'(flag), 16'b0111);

    // Suppressed ALU update
    alu(5'h00, 16'h0000, 1'b0, 1'b0); alu_valid = 1'b0;
    tick(); idle();
    check("novalid_hold", 16'(flag), 16'b0111);

    // Explicit write beats ALU
    alu(5'h00, 16'h0000, 1'b0, 1'b0); wr(4'b0101);
    tick(); idle();
    check("wr_prio", 16'(flag), 16'b0101);
    cond = 3'd6; #1; check("cond_ov", 16'(cond_true), 16'd0);
    cond = 3'd5; #1; check("cond_le", 16'(cond_true), 16'd1);
    cond = 3'd0; #1; check("cond_ne", 16'(cond_true), 16'd1);
    cond = 3'd4; #1; check("cond_ge", 16'(cond_true), 16'd0);
    cond = 3'd7; #1; check("cond_unc", 16'(cond_true), 16'd1);

    // Push saves pre-update flags while ALU updates
    wr(4'b1000);
    tick(); idle();
    push = 1'b1; alu(5'h00, 16'h8000, 1'b0, 1'b1);
    tick(); idle();
    check("push_flag", 16'(flag), 16'b0011);
    check("push_cnt", 16'(stack_cnt), 16'd1);
    pop = 1'b1;
    tick(); idle();
    check("pop_flag", 16'(flag), 16'b1000);
    check("pop_cnt", 16'(stack_cnt), 16'd0);

    // Fill the stack
    wr(fill[0]);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1;
      wr((i == 3) ? 4'b1111 : fill[i+1]);
      tick(); idle();
    end
    check("fill_cnt", 16'(stack_cnt), 16'd4);
    check("fill_full", 16'(stack_full), 16'd1);
    push = 1'b1;
    tick(); idle();
    check("ovf_err", 16'(stack_err), 16'd1);
    check("ovf_cnt", 16'(stack_cnt), 16'd4);
    tick();
    check("ovf_err_clr", 16'(stack_err), 16'd0);

    // LIFO drain
    for (int i = 3; i >= 0; i--) begin
      pop = 1'b1;
      tick(); idle();
      check($sformatf("drain%0d", i), 16'(flag), 16'(fill[i]));
    end
    check("drain_empty", 16'(stack_empty), 16'd1);
    pop = 1'b1;
    tick(); idle();
    check("unf_err", 16'(stack_err), 16'd1);
    check("unf_flag", 16'(flag), 16'b0001);
    check("unf_cnt", 16'(stack_cnt), 16'd0);

    // Simultaneous push and pop
    push = 1'b1;
    tick(); idle();
    push = 1'b1; pop = 1'b1;
    tick(); idle();
    check("pp_err", 16'(stack_err), 16'd1);
    check("pp_cnt", 16'(stack_cnt), 16'd1);
    check("pp_flag", 16'(flag), 16'b0001);

    // Asynchronous reset mid-sequence
    push = 1'b1;
    tick();
    tick(); idle();
    check("pre_rst_cnt", 16'(stack_cnt), 16'd3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cnt", 16'(stack_cnt), 16'd0);
    check("arst_flag", 16'(flag), 16'h0);
    check("arst_empty", 16'(stack_empty), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Parametrised condition-flag unit for the CPU execute stage: captures Z/C/V/N from the ALU result according to a per-opcode update mask, and lets software write the flags explicitly. It holds a hardware save stack so interrupt entry/return can push and pop flags. It also evaluates the branch condition against the current flags. It sits between the ALU and the branch/PC logic.

## Interface
- DATA_W, 16: ALU result width.
- OPC_W, 5: opcode width.
- STACK_DEPTH, 4: flag save-stack entries, ≥1.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result this cycle is architectural; when 0 the ALU update is suppressed.
- opcode  in  OPC_W  opcode of the ALU result.
- aluout  in  DATA_W  ALU result.
- alu_carry  in  1  carry out / last bit shifted out.
- aluovfl  in  1  signed overflow.
- flag_wr  in  1  explicit flag write.
- flag_wdata  in  4  {z,c,v,n} for flag_wr.
- push  in  1  save current flags to stack (interrupt entry).
- pop  in  1  restore flags from stack (interrupt return).
- cond  in  3  branch condition select.
- flag  out  4  {z,c,v,n}, registered.
- cond_true  out  1  cond evaluated on `flag`, combinational.
- stack_cnt  out  $clog2(STACK_DEPTH+1)  occupied entries.
- stack_full  out  1  stack_cnt == STACK_DEPTH.
- stack_empty  out  1  stack_cnt == 0.
- stack_err  out  1  one-cycle pulse on an illegal stack operation.

## Operation
- Update mask from opcode:
  - 0x0, 0x1 (add/sub): Z, C, V, N.
  - 0x2–0x4 (logic): Z only.
  - 0x5–0x7 (shifts): Z, N, C.
  - All other opcodes: none.
- Flag values:
  - Z = (aluout == 0).
  - N = aluout[DATA_W-1].
  - C = alu_carry.
  - V = aluovfl.
  - Unmasked bits hold.
- Next-flag priority, highest first:
  1. Legal pop: flags ← top entry.
  2. flag_wr: flags ← flag_wdata.
  3. alu_valid: masked ALU update.
  4. Otherwise: hold.
- Push stores the current registered flags, i.e. the value before this cycle's update. The flag update from priorities 2–4 still applies in the same cycle.
- Stack is LIFO: entries [0..STACK_DEPTH-1] plus a count.
- Push when full: stack unchanged, stack_err=1.
- Pop when empty: stack unchanged, flags follow priorities 2–4, stack_err=1.
- Push and pop in the same cycle: stack unchanged, flags follow priorities 2–4, stack_err=1.
- cond encoding (x = n^v):
  - 0 NE: !z
  - 1 EQ: z
  - 2 GT: !z & !x
  - 3 LT: x
  - 4 GE: !x
  - 5 LE: z | x
  - 6 OV: v
  - 7 UNC: 1

## Timing
- Reset (rst=0, asynchronous): flag=0, stack_cnt=0, stack_empty=1, stack_full=0, stack_err=0. Stack contents are don't-care.
- Reset asserted mid-operation discards stack contents immediately.
- ALU/write/pop effects appear on `flag` one cycle after the driving edge. cond_true follows `flag` in the same cycle.
- stack_cnt, stack_full and stack_empty update on the edge that performs the push or pop.
- stack_err is registered: it is high for the single cycle after the offending edge.
- No back-pressure: push and pop are single-cycle requests, and the issuer checks stack_full/stack_empty.

## Structure
- Package `flag_pkg`:
  - flag_t struct {z,c,v,n}.
  - cond_e enum.
  - Opcode constants OP_ADD=0x0, OP_SUB=0x1, OP_AND…OP_SHx.
  - Function upd_mask(opcode) returning flag_t.
  - Function eval_cond(flag_t, cond_e).
- Sub-module `flag_stack` (parametrised LIFO of flag_t with push/pop/count/full/empty/err). The top level holds the flag register, priority mux and condition logic.

## Test plan
- Reset then ADD (opcode 0x0, aluout=0x8000, alu_carry=1, aluovfl=1) -> flag={0,1,1,1}. With cond=3 (LT), cond_true=0 because n=v.
- SUB (opcode 0x1) aluout=0x0000, aluovfl=0, carry=0 -> flag={1,0,0,0}. Then AND (opcode 0x2) aluout=0x00F0 -> flag={0,0,0,0} with only Z changed. Then opcode 0x1F -> flag unchanged.
- alu_valid=0 with ADD aluout=0 -> flag unchanged. flag_wr=1, wdata=0b0101 with an ADD in the same cycle -> flag=0101.
- Push flags A=0b1000 while an ADD produces 0b0011 in the same cycle -> flag=0011, stack_cnt=1. Pop -> flag=1000, stack_cnt=0.
- STACK_DEPTH pushes, then one more -> stack_full=1, extra push ignored, stack_err high one cycle. Pops return entries in reverse order. Pop when empty -> stack_err, flags unchanged.
- Push+pop in the same cycle -> stack_err, stack_cnt unchanged. Assert rst low mid-sequence with stack_cnt=3 -> stack_cnt=0 and flag=0 asynchronously.
